apb4_slave: RTL and testbench

- APB4 (AMBA APB protocol v2.0) completer backed by an internal word-addressed register memory.
- Sits behind an APB bridge/requester on the peripheral bus.
- Serves single read/write transfers with byte strobes, configurable wait states and error response for out-of-range addresses.

---
 rtl/apb4_slave.sv | 150 +++++++++++++++
 tb/tb_apb4_slave.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb4_slave.sv
// Purpose: APB4 completer over a word-addressed register file with byte-lane writes and error response.
// Latency: PREADY rises 3 PCLK edges after the setup phase begins, plus WAIT_STATES cycles.
// Backpressure: holds PREADY low for WAIT_STATES access cycles and stalls the requester in ACCESS; it never drops a held transfer.
module apb4_slave #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic [2:0]              PPROT,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int         STRB_W   = DATA_WIDTH / 8;
    localparam int         IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Decoded view of the address currently on the bus.
    typedef struct packed {
        logic             err;
        logic [IDX_W-1:0] idx;
    } req_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    rdy_q, rdy_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   rd_dat_q, rd_dat_d;
    logic                    wr_vld;
    logic [31:0]             word_idx;
    req_t                    req;
    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    // Protection attributes are accepted but carry no meaning for this register file.
    logic unused_pprot;
    assign unused_pprot = ^PPROT;

    assign word_idx = 32'(PADDR[ADDR_WIDTH-1:2]);

    // Flag misaligned or beyond-depth accesses; the truncated index is only used when err is clear.
    always_comb begin
        req     = '0;
        req.err = (PADDR[1:0] != 2'b00) || (word_idx >= 32'(MEM_DEPTH));
        req.idx = word_idx[IDX_W-1:0];
    end

    // Next-state and registered-output values; completion is decided one edge ahead of PREADY.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdy_d    = 1'b0;
        err_d    = 1'b0;
        rd_dat_d = '0;
        wr_vld   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                // PSEL with PENABLE but no setup phase is a protocol violation and is ignored.
                if (PSEL && !PENABLE) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d = '0;
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (PENABLE) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (rdy_q) begin
                    // Completion cycle just ended: leave the access and reopen for a new setup.
                    cnt_d   = '0;
                    state_d = (PSEL && !PENABLE) ? SETUP : IDLE;
                end else if (!PSEL) begin
                    // Requester abandoned the transfer; nothing is committed.
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q != WAIT_CNT) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    rdy_d  = 1'b1;
                    err_d  = req.err;
                    wr_vld = PWRITE && !req.err;
                    if (!PWRITE && !req.err) begin
                        rd_dat_d = mem[req.idx];
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM, wait counter and bus outputs; reset forces every output low at once.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rdy_q    <= 1'b0;
            err_q    <= 1'b0;
            rd_dat_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdy_q    <= rdy_d;
            err_q    <= err_d;
            rd_dat_q <= rd_dat_d;
        end
    end

    // Register file: cleared on reset, byte lanes updated only on an error-free write completion.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_vld) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (PSTRB[b]) begin
                    mem[req.idx][8*b +: 8] <= PWDATA[8*b +: 8];
                end
            end
        end
    end

    assign PREADY  = rdy_q;
    assign PSLVERR = err_q;
    assign PRDATA  = rd_dat_q;

endmodule

// File: tb/tb_apb4_slave.sv
// Purpose: scoreboard bench for apb4_slave; two instances (0 and 2 wait states) on separate buses.
// Latency: expects PREADY 3 cycles after setup start on dev 0 and 5 cycles on dev 1.
// Backpressure: the driver holds each transfer until PREADY, bounded by a cycle budget.
`timescale 1ns/1ps
module tb_apb4_slave;

    typedef struct {
        int          dev;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [7:0]  paddr   [2];
    logic [31:0] pwdata  [2];
    logic [3:0]  pstrb   [2];
    logic [2:0]  pprot   [2];
    logic [31:0] prdata  [2];
    logic        pready  [2];
    logic        pslverr [2];

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   start_cyc [2];

    apb4_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .MEM_DEPTH(32), .WAIT_STATES(0)) dut0 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(penable[0]),
        .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PSTRB(pstrb[0]),
        .PPROT(pprot[0]), .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0])
    );

    apb4_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .MEM_DEPTH(32), .WAIT_STATES(2)) dut1 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(penable[1]),
        .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PSTRB(pstrb[1]),
        .PPROT(pprot[1]), .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1])
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Free-running cycle count used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s dev=%0d actual=%h required=%h t=%0t", nm, d, act, req, $time);
        end
    endtask

    // Pops one expectation per PREADY pulse; outside completion the outputs must read zero.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (psel[d] && !penable[d]) start_cyc[d] = cyc;
                if (pready[d] === 1'b1) begin
                    if (sb.size() == 0 || sb[0].dev != d) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_pready dev=%0d actual=1 required=0 t=%0t", d, $time);
                    end else begin
                        e = sb.pop_front();
                        chk("prdata", d, prdata[d], e.rdata);
                        chk("pslverr", d, 32'(pslverr[d]), 32'(e.err));
                        chk("latency", d, 32'(cyc - start_cyc[d]), 32'(e.lat));
                    end
                end else begin
                    chk("idle_pready", d, 32'(pready[d]), 32'd0);
                    chk("idle_pslverr", d, 32'(pslverr[d]), 32'd0);
                    chk("idle_prdata", d, prdata[d], 32'd0);
                end
            end
        end
    endtask

    // Runs one transfer from setup through completion; returns #1 after the completing edge with PSEL still high.
    task automatic xfer(input int d, input logic wr, input logic [7:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        logic got;
        e.dev   = d;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.lat   = (d == 0) ? 3 : 5;
        sb.push_back(e);
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite[d]  = wr;
        paddr[d]   = a;
        pwdata[d]  = wd;
        pstrb[d]   = st;
        pprot[d]   = 3'b010;
        @(posedge clk); #1;
        penable[d] = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 32 && !got; n++) begin
            @(negedge clk);
            got = pready[d];
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout dev=%0d addr=%h actual=no_pready required=pready", d, a);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        for (int d = 0; d < 2; d++) begin
            psel[d]    = 1'b0;
            penable[d] = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0; paddr[d] = 8'h00;
            pwdata[d] = 32'h0; pstrb[d] = 4'h0; pprot[d] = 3'b000; start_cyc[d] = 0;
        end
        fork
            monitor();
        join_none

        // Reset window 1..31 ns, outputs checked inside it.
        #1 rst_n = 1'b0;
        #14;
        for (int d = 0; d < 2; d++) begin
            chk("rst_pready", d, 32'(pready[d]), 32'd0);
            chk("rst_pslverr", d, 32'(pslverr[d]), 32'd0);
            chk("rst_prdata", d, prdata[d], 32'd0);
        end
        #10;
        for (int d = 0; d < 2; d++) chk("rst_pready_late", d, 32'(pready[d]), 32'd0);
        #6 rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic read, full write, partial write.
        xfer(0, 1'b0, 8'h00, 32'h0, 4'hF, 32'h0000_0000, 1'b0);
        idle();
        xfer(0, 1'b1, 8'h04, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
        idle();
        xfer(0, 1'b0, 8'h04, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0);
        idle();
        xfer(0, 1'b1, 8'h04, 32'h1122_3344, 4'b0101, 32'h0, 1'b0);
        idle();
        xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0);
        idle();

        // Errors: beyond depth (would alias word 0), top of map, misaligned; memory must not move.
        xfer(0, 1'b1, 8'h80, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b1);
        idle();
        xfer(0, 1'b0, 8'h00, 32'h0, 4'hF, 32'h0000_0000, 1'b0);
        idle();
        xfer(0, 1'b0, 8'hFC, 32'h0, 4'hF, 32'h0, 1'b1);
        idle();
        xfer(0, 1'b0, 8'h7C, 32'h0, 4'hF, 32'h0000_0000, 1'b0);
        idle();
        xfer(0, 1'b0, 8'h06, 32'h0, 4'hF, 32'h0, 1'b1);
        idle();
        xfer(0, 1'b1, 8'h05, 32'h0000_0000, 4'hF, 32'h0, 1'b1);
        idle();
        xfer(0, 1'b1, 8'h04, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0);
        idle();
        xfer(0, 1'b0, 8'h04, 32'h0, 4'hF, 32'hDE22_BE44, 1'b0);
        idle();

        // Two wait states.
        xfer(1, 1'b1, 8'h08, 32'h0000_A5A5, 4'hF, 32'h0, 1'b0);
        idle();
        xfer(1, 1'b0, 8'h08, 32'h0, 4'hF, 32'h0000_A5A5, 1'b0);
        idle();

        // Back-to-back write then read with no idle cycle between.
        xfer(0, 1'b1, 8'h10, 32'h5A5A_1234, 4'hF, 32'h0, 1'b0);
        xfer(0, 1'b0, 8'h10, 32'h0, 4'hF, 32'h5A5A_1234, 1'b0);
        idle();

        // PSEL+PENABLE with no setup phase must be ignored.
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b0; paddr[0] = 8'h10;
        repeat (4) @(posedge clk);
        #1;
        chk("violation_pready", 0, 32'(pready[0]), 32'd0);
        idle();

        // Reset during the completion cycle of a read: outputs clear at once, memory cleared.
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b0; paddr[0] = 8'h10;
        @(posedge clk); #1;
        penable[0] = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        chk("pre_rst_pready", 0, 32'(pready[0]), 32'd1);
        chk("pre_rst_prdata", 0, prdata[0], 32'h5A5A_1234);
        rst_n = 1'b0;
        #1;
        chk("midrst_pready", 0, 32'(pready[0]), 32'd0);
        chk("midrst_pslverr", 0, 32'(pslverr[0]), 32'd0);
        chk("midrst_prdata", 0, prdata[0], 32'd0);
        @(posedge clk); #1;
        psel[0] = 1'b0; penable[0] = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(0, 1'b0, 8'h10, 32'h0, 4'hF, 32'h0000_0000, 1'b0);
        idle();
        xfer(0, 1'b0, 8'h04, 32'h0, 4'hF, 32'h0000_0000, 1'b0);
        idle();
        xfer(1, 1'b0, 8'h08, 32'h0, 4'hF, 32'h0000_0000, 1'b0);
        idle();

        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL leftover_expect actual=%0d required=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
